// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO placed downstream of the UART receiver, with a sticky overflow flag.
// Optional macro UART_RX_FIFO_BREAK_DROP_EN: drop BREAK strobes and flag them on brk_seen.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_break,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              brk_seen
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_overflow;

  logic [ADDR_W:0]   w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_wr_req;
  logic              w_push;
  logic              w_drop;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == (ADDR_W+1)'(DEPTH));
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_pop   = !w_empty && out_ready;

`ifdef UART_RX_FIFO_BREAK_DROP_EN
  logic w_brk;
  logic r_brk_seen;

  assign w_brk    = rx_valid && rx_break;
  assign w_wr_req = rx_valid && !rx_break;

  always_ff @(posedge clk) begin
    if (!resetn)
      r_brk_seen <= 1'b0;
    else if (w_brk)
      r_brk_seen <= 1'b1;
    else if (clr_ovf)
      r_brk_seen <= 1'b0;
  end

  assign brk_seen = r_brk_seen;
`else
  logic w_unused_brk;

  assign w_wr_req     = rx_valid;
  assign w_unused_brk = rx_break;
  assign brk_seen     = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the strobe.
  assign w_push = w_wr_req && (!w_full || w_pop);
  assign w_drop = w_wr_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clr_ovf)
        r_overflow <= 1'b0;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = w_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a negedge monitor checks pops.
// Honours UART_RX_FIFO_BREAK_DROP_EN the same way as the design.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk;
  logic              resetn;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_break;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              clr_ovf;
  logic              brk_seen;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .clr_ovf(clr_ovf), .brk_seen(brk_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head entry must match the oldest expected byte.
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected nothing", out_data);
      end else begin
        if (out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit accepted);
    rx_valid = 1'b1;
    rx_data  = d;
    if (accepted) exp_q.push_back(d);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (empty !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check({name, "_timeout"}, (n < 64), 1);
    check({name, "_qleft"}, exp_q.size(), 0);
    check({name, "_level"}, level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int max_lvl;
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_break = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_brk", brk_seen, 0);

    // Single byte, FWFT latency
    push(8'hA5, 1);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'hA5);
    check("t1_level", level, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_empty", empty, 1);
    check("t1_level0", level, 0);

    // Fill, overflow, set-wins, full push+pop
    for (int i = 1; i <= 16; i++) push(8'(i), 1);
    check("t2_full", full, 1);
    check("t2_level", level, 16);
    check("t2_ovf0", overflow, 0);
    push(8'h11, 0);
    check("t2_ovf", overflow, 1);
    check("t2_level_hold", level, 16);
    clr_ovf = 1'b1;
    push(8'h12, 0);
    clr_ovf = 1'b0;
    check("t2_setwins", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t2_clr", overflow, 0);
    out_ready = 1'b1;
    push(8'h55, 1);
    out_ready = 1'b0;
    check("t3_ovf", overflow, 0);
    check("t3_level", level, 16);
    check("t3_full", full, 1);
    drain("t3_drain");

    // Push/pop pairs across pointer wrap
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'b1;
      push(8'(i * 7 + 3), 1);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      tick();
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    out_ready = 1'b0;
    check("t4_maxlvl_le1", (max_lvl <= 1), 1);
    check("t4_empty", empty, 1);
    check("t4_qleft", exp_q.size(), 0);

    // Mid-operation reset flush
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1);
    check("t5_level5", level, 5);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_q.delete();
    check("t5_empty", empty, 1);
    check("t5_level", level, 0);
    check("t5_ovf", overflow, 0);
    push(8'hC3, 1);
    check("t5_data", out_data, 8'hC3);
    drain("t5_drain");

    // BREAK character
    rx_break = 1'b1;
`ifdef UART_RX_FIFO_BREAK_DROP_EN
    push(8'h00, 0);
    rx_break = 1'b0;
    check("t6_level", level, 0);
    check("t6_brk", brk_seen, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t6_brk_clr", brk_seen, 0);
`else
    push(8'h00, 1);
    rx_break = 1'b0;
    check("t6_level", level, 1);
    check("t6_data", out_data, 8'h00);
    check("t6_brk", brk_seen, 0);
    drain("t6_drain");
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
